hdlverifier_reg_access_arbiter: RTL and testbench



---
 rtl/hdlverifier_pkg.sv | 27 ++
 rtl/hdlverifier_rr_select.sv | 31 +++
 rtl/hdlverifier_reg_access_arbiter.sv | 130 +++++++++++++
 tb/tb_hdlverifier_reg_access_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlverifier_pkg.sv
// Shared types and defaults for the register access arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package hdlverifier_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ  = 3;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_READ_LAT = 1;

  // WAIT down-counter width; READ_LAT never exceeds 4.
  localparam int CNT_W = 3;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hdlverifier_rr_select.sv
// Round-robin winner selection among pending requesters.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is consumed.
// Ports: req (pending requests), last_owner (previous winner),
//        winner (index of the selected requester), valid (any request pending).
module hdlverifier_rr_select
  import hdlverifier_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Search starts just after the last owner and wraps; the last owner is
  // visited last so it gets the lowest priority.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!valid && req[IDX_W'((int'(last_owner) + k) % NUM_REQ)]) begin
        winner = IDX_W'((int'(last_owner) + k) % NUM_REQ);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdlverifier_reg_access_arbiter.sv
// Arbitrates NUM_REQ requesters onto one register-file port, round-robin.
// Latency: req edge k -> ISSUE k+1; write ack k+2, read ack k+2+READ_LAT.
// Backpressure: req is a level held until ack; one access at a time, one IDLE gap.
// Ports: clk, reset_n; req/req_write/req_addr/req_wdata (packed per requester);
//        gnt, ack, rd_data to requesters; reg_addr/reg_wdata/reg_write/reg_rdata
//        to the register file; busy while not idle.
module hdlverifier_reg_access_arbiter
  import hdlverifier_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         reg_addr,
  output logic [DATA_W-1:0]         reg_wdata,
  output logic                      reg_write,
  input  logic [DATA_W-1:0]         reg_rdata,
  output logic                      busy
);

  localparam int IDX_W = idx_w(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_owner;
  logic               cmd_write;
  logic [CNT_W-1:0]   wait_cnt;

  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  // Unpack the flat per-requester buses for indexed selection.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  hdlverifier_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (req),
    .last_owner (last_owner),
    .winner     (win_idx),
    .valid      (win_vld)
  );

  // reg_addr/reg_wdata double as the latched command: they are loaded at
  // arbitration and held, so later req_* changes cannot disturb the access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      cmd_write  <= 1'b0;
      wait_cnt   <= '0;
      gnt        <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      reg_write  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      rd_data    <= '0;
    end else begin
      reg_write <= 1'b0;
      ack       <= '0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            state        <= ST_ISSUE;
            owner        <= win_idx;
            cmd_write    <= req_write[win_idx];
            reg_addr     <= addr_arr[win_idx];
            reg_wdata    <= data_arr[win_idx];
            reg_write    <= req_write[win_idx];
            gnt          <= '0;
            gnt[win_idx] <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (cmd_write) begin
            state      <= ST_ACK;
            ack[owner] <= 1'b1;
            last_owner <= owner;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= CNT_W'(READ_LAT);
          end
        end
        ST_WAIT: begin
          // Last WAIT cycle is when registered read data is valid.
          if (wait_cnt == CNT_W'(1)) begin
            state      <= ST_ACK;
            wait_cnt   <= '0;
            rd_data    <= reg_rdata;
            ack[owner] <= 1'b1;
            last_owner <= owner;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdlverifier_reg_access_arbiter.sv
// Self-checking bench: transaction-level timing model plus directed literals.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// A second instance with READ_LAT=4 is checked only in the long-read window.
module tb_hdlverifier_reg_access_arbiter;

  localparam int N   = 3;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int RL1 = 1;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   reg_rdata;

  logic [N-1:0]    gnt, ack, gnt_4, ack_4;
  logic [DW-1:0]   rd_data, reg_wdata, rd_data_4, reg_wdata_4;
  logic [AW-1:0]   reg_addr, reg_addr_4;
  logic            reg_write, busy, reg_write_4, busy_4;

  int              checks = 0;
  int              errors = 0;
  int              cyc    = 0;
  logic            rd_count_en;
  logic [DW-1:0]   rd_fixed;

  hdlverifier_reg_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL1)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rd_data(rd_data), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_write(reg_write), .reg_rdata(reg_rdata), .busy(busy)
  );

  hdlverifier_reg_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(4)) u_dut_4 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt_4), .ack(ack_4), .rd_data(rd_data_4), .reg_addr(reg_addr_4),
    .reg_wdata(reg_wdata_4), .reg_write(reg_write_4), .reg_rdata(reg_rdata), .busy(busy_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counting read data makes the capture cycle observable.
  always @(negedge clk) cyc <= cyc + 1;
  assign reg_rdata = rd_count_en ? {16'hC0DE, cyc[15:0]} : rd_fixed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int ack_time(input logic w);
    return w ? 2 : 2 + RL1;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return 0;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // ---- transaction model: cycle offset m_t since the arbitration edge ----
  logic          m_act, m_wr;
  int            m_t, m_own, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act <= 1'b0; m_t <= 0; m_own <= 0; m_wr <= 1'b0; m_last <= N - 1;
      m_addr <= '0; m_wdata <= '0; m_rd <= '0;
    end else if (!m_act) begin
      if (req != '0) begin
        m_act   <= 1'b1;
        m_t     <= 1;
        m_own   <= pick(req, m_last);
        m_wr    <= req_write[pick(req, m_last)];
        m_addr  <= req_addr[pick(req, m_last)*AW +: AW];
        m_wdata <= req_wdata[pick(req, m_last)*DW +: DW];
      end
    end else if (m_t == ack_time(m_wr)) begin
      m_act  <= 1'b0;
      m_last <= m_own;
    end else begin
      m_t <= m_t + 1;
      if (!m_wr && (m_t + 1 == ack_time(m_wr))) m_rd <= reg_rdata;
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("m_busy", 64'(busy), 64'(m_act));
      chk("m_gnt", 64'(gnt), m_act ? 64'(1) << m_own : 64'd0);
      chk("m_ack", 64'(ack), (m_act && m_t == ack_time(m_wr)) ? 64'(1) << m_own : 64'd0);
      chk("m_reg_write", 64'(reg_write), 64'(m_act && m_t == 1 && m_wr));
      chk("m_reg_addr", 64'(reg_addr), 64'(m_addr));
      chk("m_reg_wdata", 64'(reg_wdata), 64'(m_wdata));
      chk("m_rd_data", 64'(rd_data), 64'(m_rd));
    end
  end

  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_ack"}, 64'(ack), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_reg_write"}, 64'(reg_write), 64'd0);
    chk({tag, "_reg_addr"}, 64'(reg_addr), 64'd0);
    chk({tag, "_reg_wdata"}, 64'(reg_wdata), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
  endtask

  int            seq [4];
  int            exp_seq [4];
  int            ack_cnt [N];
  int            n_gnt, n_ack;
  logic [N-1:0]  prev_gnt;

  initial begin
    reset_n = 1'b0; rd_count_en = 1'b0; rd_fixed = '0;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Single write by requester 1.
    set_cmd(1, 1'b1, 5'h02, 32'hDEADBEEF);
    req = 3'b010;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("wr_reg_write", 64'(reg_write), 64'd1);
        chk("wr_reg_addr", 64'(reg_addr), 64'h02);
        chk("wr_reg_wdata", 64'(reg_wdata), 64'hDEADBEEF);
        chk("wr_gnt", 64'(gnt), 64'b010);
        chk("wr_ack_early", 64'(ack), 64'd0);
      end
      if (c == 2) begin
        chk("wr_ack", 64'(ack), 64'b010);
        chk("wr_reg_write_off", 64'(reg_write), 64'd0);
        chk("wr_rd_data_kept", 64'(rd_data), 64'd0);
        req = '0;
      end
      if (c == 3) chk("wr_idle_busy", 64'(busy), 64'd0);
    end

    // Single read by requester 0; the READ_LAT=4 instance sees the same request.
    set_cmd(0, 1'b0, 5'h01, 32'h0);
    rd_fixed = 32'h12345678;
    req = 3'b001;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("rd_gnt", 64'(gnt), 64'b001);
        chk("rd_reg_addr", 64'(reg_addr), 64'h01);
        chk("rd_reg_write", 64'(reg_write), 64'd0);
      end
      if (c == 2) chk("rd_ack_wait", 64'(ack), 64'd0);
      if (c == 3) begin
        chk("rd_ack", 64'(ack), 64'b001);
        chk("rd_data", 64'(rd_data), 64'h12345678);
        req = '0;
      end
      chk("rl4_busy", 64'(busy_4), 64'(c <= 6));
      chk("rl4_ack", 64'(ack_4), (c == 6) ? 64'b001 : 64'd0);
      if (c == 6) chk("rl4_rd_data", 64'(rd_data_4), 64'h12345678);
    end

    // Contention after reset: all three held, grants must rotate 0,1,2,0.
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    rd_count_en = 1'b1;
    set_cmd(0, 1'b1, 5'h10, 32'hAAAA0000);
    set_cmd(1, 1'b0, 5'h11, 32'hBBBB1111);
    set_cmd(2, 1'b1, 5'h12, 32'hCCCC2222);
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 0;
    n_gnt = 0; n_ack = 0; prev_gnt = '0;
    for (int i = 0; i < 4; i++) seq[i] = -1;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    req = 3'b111;
    for (int c = 0; c < 60 && n_ack < 4; c++) begin
      @(negedge clk);
      if (gnt != '0 && prev_gnt == '0) begin
        if (n_gnt < 4) seq[n_gnt] = oh2i(gnt);
        n_gnt++;
      end
      if (ack != '0) begin
        chk("rr_ack_matches_gnt", 64'(ack), 64'(gnt));
        if (oh2i(ack) >= 0) ack_cnt[oh2i(ack)]++;
        n_ack++;
        if (n_ack == 4) req = '0;
      end
      prev_gnt = gnt;
    end
    req = '0;
    rd_count_en = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order_%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
    chk("rr_grants", 64'(n_gnt), 64'd4);
    chk("rr_acks", 64'(n_ack), 64'd4);
    chk("rr_ack0", 64'(ack_cnt[0]), 64'd2);
    chk("rr_ack1", 64'(ack_cnt[1]), 64'd1);
    chk("rr_ack2", 64'(ack_cnt[2]), 64'd1);
    repeat (2) @(negedge clk);

    // Requester 2 drops its read in ISSUE and scrambles its inputs.
    rd_fixed = 32'h0BADF00D;
    set_cmd(2, 1'b0, 5'h1F, 32'h5555AAAA);
    req = 3'b100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("drop_gnt", 64'(gnt), 64'b100);
        chk("drop_addr_issue", 64'(reg_addr), 64'h1F);
        req = '0;
        set_cmd(2, 1'b1, 5'h0A, 32'h01234567);
      end
      if (c == 2) chk("drop_addr_held", 64'(reg_addr), 64'h1F);
      if (c == 3) begin
        chk("drop_ack", 64'(ack), 64'b100);
        chk("drop_rd_data", 64'(rd_data), 64'h0BADF00D);
      end
      if (c >= 4) chk("drop_no_regrant", 64'(gnt), 64'd0);
    end

    // Requester 1 completes (pointer now 1), then a read by 0 is reset in WAIT.
    set_cmd(1, 1'b1, 5'h03, 32'hFEEDFACE);
    req = 3'b010;
    repeat (2) @(negedge clk);
    chk("pre_rst_ack", 64'(ack), 64'b010);
    req = '0;
    @(negedge clk);
    set_cmd(0, 1'b0, 5'h07, 32'h0);
    req = 3'b001;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    req = '0;
    @(negedge clk);
    chk_all_zero("rst_wait");
    @(negedge clk);
    chk_all_zero("rst_wait2");
    #2 reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_no_ack", 64'(ack), 64'd0);
      chk("post_rst_no_write", 64'(reg_write), 64'd0);
    end
    // With the pointer reset, requester 1 outranks requester 2.
    set_cmd(1, 1'b1, 5'h04, 32'h11112222);
    set_cmd(2, 1'b1, 5'h05, 32'h33334444);
    req = 3'b110;
    @(negedge clk);
    chk("post_rst_gnt", 64'(gnt), 64'b010);
    @(negedge clk);
    chk("post_rst_ack", 64'(ack), 64'b010);
    req = '0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
